// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op encodings, aluop classes, funct codes and status flag type
package alu_pkg;
    localparam int DW = 32;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;
    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_AND = 4'b0100;
    localparam logic [3:0] FN_OR  = 4'b0101;
    localparam logic [3:0] FN_NOR = 4'b0111;
    localparam logic [3:0] FN_SLT = 4'b1010;
    typedef struct packed {
        logic v;
        logic z;
        logic n;
    } status_t;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: execute-stage operand, result and status bundle
interface alu_exec_unit_if;
    logic        aluop1;
    logic        aluop0;
    logic [3:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm_ext;
    logic [2:0]  gout;
    logic [31:0] alu_result;
    logic        zout;
    logic        vout;
    logic        nout;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        v_flag;
    logic        z_flag;
    logic        n_flag;
    modport master (
        output aluop1, aluop0, funct, a, b, pc, imm_ext,
        input  gout, alu_result, zout, vout, nout, pc_plus4, branch_target, v_flag, z_flag, n_flag
    );
    modport slave (
        input  aluop1, aluop0, funct, a, b, pc, imm_ext,
        output gout, alu_result, zout, vout, nout, pc_plus4, branch_target, v_flag, z_flag, n_flag
    );
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: aluop class / funct to 3-bit ALU op; ALU_NOR_EN adds funct 0111 -> NOR
module alu_op_decode
    import alu_pkg::*;
(
    input  logic       aluop1_i,
    input  logic       aluop0_i,
    input  logic [3:0] funct_i,
    output logic [2:0] gout_o
);
    always_comb begin
        gout_o = OP_ADD;
        case ({aluop1_i, aluop0_i})
            ALUOP_SUB: gout_o = OP_SUB;
            ALUOP_ORI: gout_o = OP_OR;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FN_SUB: gout_o = OP_SUB;
                    FN_AND: gout_o = OP_AND;
                    FN_OR:  gout_o = OP_OR;
                    FN_SLT: gout_o = OP_SLT;
`ifdef ALU_NOR_EN
                    FN_NOR: gout_o = OP_NOR;
`else
                    FN_NOR: gout_o = OP_ADD;
`endif
                    default: gout_o = OP_ADD;
                endcase
            end
            default: gout_o = OP_ADD;
        endcase
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS-lite execute slice (decode, ALU, PC adders, V/Z/N status register).
// Define ALU_NOR_EN to enable the R-type NOR operation.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = DW,
    parameter int PC_INC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_exec_unit_if.slave        bus
);
    logic [2:0]       gout;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             v_add;
    logic             v_sub;
    logic             slt;
    logic             vo;
    status_t          flags_d;
    status_t          flags_q;

    alu_op_decode u_dec (
        .aluop1_i (bus.aluop1),
        .aluop0_i (bus.aluop0),
        .funct_i  (bus.funct),
        .gout_o   (gout)
    );

    assign sum   = bus.a + bus.b;
    assign diff  = bus.a - bus.b;
    assign v_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    assign v_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    // overflow-corrected sign keeps SLT right at the signed extremes
    assign slt   = diff[WIDTH-1] ^ v_sub;

    always_comb begin
        res = sum;
        vo  = v_add;
        case (gout)
            OP_AND: begin res = bus.a & bus.b; vo = 1'b0; end
            OP_OR:  begin res = bus.a | bus.b; vo = 1'b0; end
            OP_SUB: begin res = diff;          vo = v_sub; end
            OP_SLT: begin res = WIDTH'(slt);   vo = 1'b0; end
`ifdef ALU_NOR_EN
            OP_NOR: begin res = ~(bus.a | bus.b); vo = 1'b0; end
`else
            OP_NOR: begin res = sum; vo = v_add; end
`endif
            default: begin res = sum; vo = v_add; end
        endcase
    end

    assign bus.gout          = gout;
    assign bus.alu_result    = res;
    assign bus.zout          = (res == '0);
    assign bus.vout          = vo;
    assign bus.nout          = res[WIDTH-1];
    assign bus.pc_plus4      = bus.pc + PC_INC;
    assign bus.branch_target = bus.pc_plus4 + (bus.imm_ext << 2);

    assign flags_d = '{v: vo, z: (res == '0), n: res[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (rst) flags_q <= '0;
        else     flags_q <= flags_d;
    end

    assign bus.v_flag = flags_q.v;
    assign bus.z_flag = flags_q.z;
    assign bus.n_flag = flags_q.n;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed scoreboard bench for alu_exec_unit.
module tb_alu_exec_unit;
    import alu_pkg::*;

    typedef struct packed {
        logic [2:0]  g;
        logic [31:0] r;
        logic        z;
        logic        v;
        logic        n;
        logic [31:0] p4;
        logic [31:0] bt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    exp_t q[$];
    logic [2:0] fq[$];

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [3:0] fn,
                                   input logic [31:0] av, input logic [31:0] bv,
                                   input logic [31:0] pcv, input logic [31:0] imm);
        exp_t m;
        logic [32:0] s;
        if (op == 2'b00) m.g = 3'b010;
        else if (op == 2'b01) m.g = 3'b110;
        else if (op == 2'b11) m.g = 3'b001;
        else if (fn == 4'b0010) m.g = 3'b110;
        else if (fn == 4'b0100) m.g = 3'b000;
        else if (fn == 4'b0101) m.g = 3'b001;
        else if (fn == 4'b1010) m.g = 3'b111;
`ifdef ALU_NOR_EN
        else if (fn == FN_NOR) m.g = OP_NOR;
`endif
        else m.g = 3'b010;
        m.v = 1'b0;
        case (m.g)
            3'b000: m.r = av & bv;
            3'b001: m.r = av | bv;
            3'b100: m.r = ~(av | bv);
            3'b111: m.r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            3'b110: begin
                s = {av[31], av} - {bv[31], bv};
                m.r = s[31:0];
                m.v = s[32] ^ s[31];
            end
            default: begin
                s = {av[31], av} + {bv[31], bv};
                m.r = s[31:0];
                m.v = s[32] ^ s[31];
            end
        endcase
        m.z = (m.r == 32'd0);
        m.n = m.r[31];
        m.p4 = pcv + 32'd4;
        m.bt = pcv + 32'd4 + {imm[29:0], 2'b00};
        return m;
    endfunction

    // Drive one instruction just after an edge, check combinational outputs mid-cycle,
    // then check the flags captured at the following edge.
    task automatic step(input logic [1:0] op, input logic [3:0] fn,
                        input logic [31:0] av, input logic [31:0] bv, input logic r);
        exp_t e;
        logic [2:0] f;
        bus.aluop1 = op[1];
        bus.aluop0 = op[0];
        bus.funct  = fn;
        bus.a      = av;
        bus.b      = bv;
        rst        = r;
        e = model(op, fn, av, bv, bus.pc, bus.imm_ext);
        q.push_back(e);
        fq.push_back(r ? 3'b000 : {e.v, e.z, e.n});
        #4;
        e = q.pop_front();
        chk("gout", 32'(bus.gout), 32'(e.g));
        chk("alu_result", bus.alu_result, e.r);
        chk("zout", 32'(bus.zout), 32'(e.z));
        chk("vout", 32'(bus.vout), 32'(e.v));
        chk("nout", 32'(bus.nout), 32'(e.n));
        chk("pc_plus4", bus.pc_plus4, e.p4);
        chk("branch_target", bus.branch_target, e.bt);
        @(posedge clk);
        #1;
        f = fq.pop_front();
        chk("flags_vzn", 32'({bus.v_flag, bus.z_flag, bus.n_flag}), 32'(f));
    endtask

    initial begin
        bus.aluop1 = 1'b0;
        bus.aluop0 = 1'b0;
        bus.funct = 4'b0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        bus.pc = 32'h0000_0010;
        bus.imm_ext = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", 32'({bus.v_flag, bus.z_flag, bus.n_flag}), 32'd0);

        step(2'b10, 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        chk("add_ovf_result", bus.alu_result, 32'h8000_0000);
        chk("add_ovf_vout", 32'(bus.vout), 32'd1);
        chk("add_ovf_vflag", 32'(bus.v_flag), 32'd1);
        chk("adder_pc_plus4", bus.pc_plus4, 32'h0000_0014);
        chk("adder_target", bus.branch_target, 32'h0000_0010);

        step(2'b01, 4'b0000, 32'h1234_5678, 32'h1234_5678, 1'b0);
        chk("sub_zero_z_flag", 32'(bus.z_flag), 32'd1);
        chk("sub_zero_n_flag", 32'(bus.n_flag), 32'd0);

        step(2'b10, 4'b1010, 32'h8000_0000, 32'h0000_0001, 1'b0);
        chk("slt_min_lt_1", bus.alu_result, 32'd1);
        step(2'b10, 4'b1010, 32'h0000_0001, 32'h8000_0000, 1'b0);
        chk("slt_1_lt_min", bus.alu_result, 32'd0);

        bus.pc = 32'hFFFF_FFFC;
        bus.imm_ext = 32'h0000_0003;
        step(2'b10, 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        chk("and_result", bus.alu_result, 32'h00F0_00F0);
        step(2'b10, 4'b0101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        chk("or_result", bus.alu_result, 32'hFFF0_FFF0);
        step(2'b11, 4'b1111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        chk("ori_result", bus.alu_result, 32'hFFF0_FFF0);
        step(2'b10, 4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
`ifdef ALU_NOR_EN
        chk("nor_result", bus.alu_result, 32'h000F_000F);
`else
        chk("f0111_add", bus.alu_result, 32'h00E1_00E0);
`endif
        step(2'b10, 4'b1111, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0);
        step(2'b00, 4'b0010, 32'h8000_0000, 32'h8000_0000, 1'b0);
        step(2'b01, 4'b0000, 32'h8000_0000, 32'h0000_0001, 1'b0);
        step(2'b10, 4'b0010, 32'h0000_0001, 32'h0000_0002, 1'b0);

        step(2'b10, 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        step(2'b10, 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        chk("reset_mid_vflag", 32'(bus.v_flag), 32'd0);
        step(2'b10, 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        chk("resume_vflag", 32'(bus.v_flag), 32'd1);

        for (int i = 0; i < 24; i++) begin
            bus.pc = $urandom;
            bus.imm_ext = $urandom;
            step(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom, $urandom, 1'b0);
        end

        chk("scoreboard_empty", 32'(q.size() + fq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
